// File: rtl/request_arbiter_rr_pkg.sv
// Shared constants and state encoding for request_arbiter_rr and other arbiters
// that feed the memory-subsystem request FIFO.
package request_arbiter_rr_pkg;

  localparam int BYTE_LEN_IN_BITS = 8;
  localparam int DEFAULT_ENTRY_WIDTH_IN_BITS = 64 * BYTE_LEN_IN_BITS;

  typedef enum logic {
    ARBITER_STATE_IDLE = 1'b0,
    ARBITER_STATE_HOLD = 1'b1
  } arbiter_state_e;

endpackage

// File: rtl/request_arbiter_rr_pick.sv
// round_robin_pick: combinational search for the first set valid bit at or above
// the pointer, wrapping from the top index back to 0. Reusable by other arbiters.
module round_robin_pick
  import request_arbiter_rr_pkg::*;
#(
  parameter int NUM_REQUESTER      = 4,
  parameter int NUM_REQUESTER_LOG2 = 2
) (
  input  logic [NUM_REQUESTER-1:0]      valid_vector,
  input  logic [NUM_REQUESTER_LOG2-1:0] pointer,
  output logic                          found,
  output logic [NUM_REQUESTER_LOG2-1:0] winner
);

  localparam logic [NUM_REQUESTER_LOG2:0] NUM_REQ_W = (NUM_REQUESTER_LOG2 + 1)'(NUM_REQUESTER);

  logic [NUM_REQUESTER_LOG2:0] idx;

  // Scan from the farthest offset down so the nearest candidate is written last.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = NUM_REQUESTER - 1; i >= 0; i--) begin
      idx = {1'b0, pointer} + (NUM_REQUESTER_LOG2 + 1)'(i);
      if (idx >= NUM_REQ_W) begin
        idx = idx - NUM_REQ_W;
      end
      if (valid_vector[idx[NUM_REQUESTER_LOG2-1:0]]) begin
        found  = 1'b1;
        winner = idx[NUM_REQUESTER_LOG2-1:0];
      end
    end
  end

endmodule

// File: rtl/request_arbiter_rr.sv
// N-to-1 round-robin arbiter in front of the request FIFO. Define
// ARBITER_FIXED_PRIORITY_EN to pin the pointer at 0 (lowest valid index wins).
//
// state | meaning
// IDLE  | nothing held, outputs 0
// HOLD  | request_out valid, waiting for issue_ack_in from the FIFO
module request_arbiter_rr
  import request_arbiter_rr_pkg::*;
#(
  parameter int SINGLE_ENTRY_WIDTH_IN_BITS = DEFAULT_ENTRY_WIDTH_IN_BITS,
  parameter int NUM_REQUESTER              = 4,
  parameter int NUM_REQUESTER_LOG2         = 2
) (
  input  logic                                               clk_in,
  input  logic                                               reset_in,
  input  logic [NUM_REQUESTER*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_packed_in,
  input  logic [NUM_REQUESTER-1:0]                           request_valid_packed_in,
  output logic [NUM_REQUESTER-1:0]                           issue_ack_packed_out,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]              request_out,
  output logic                                               request_valid_out,
  output logic [NUM_REQUESTER_LOG2-1:0]                      grant_index_out,
  input  logic                                               issue_ack_in
);

  arbiter_state_e state, state_next;

  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_next;
  logic                                  request_valid_next;
  logic [NUM_REQUESTER_LOG2-1:0]         grant_index_next;
  logic [NUM_REQUESTER-1:0]              issue_ack_next;
  logic [NUM_REQUESTER_LOG2-1:0]         pointer;
  logic                                  found;
  logic [NUM_REQUESTER_LOG2-1:0]         winner;
  logic                                  load;

  round_robin_pick #(
    .NUM_REQUESTER      (NUM_REQUESTER),
    .NUM_REQUESTER_LOG2 (NUM_REQUESTER_LOG2)
  ) u_pick (
    .valid_vector (request_valid_packed_in),
    .pointer      (pointer),
    .found        (found),
    .winner       (winner)
  );

`ifdef ARBITER_FIXED_PRIORITY_EN
  assign pointer = '0;
`else
  // Pointer moves one past the winner so it has the lowest priority next time.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      pointer <= '0;
    end else if (load) begin
      pointer <= (winner == NUM_REQUESTER_LOG2'(NUM_REQUESTER - 1)) ? '0 : winner + 1'b1;
    end
  end
`endif

  always_comb begin
    state_next         = state;
    request_next       = request_out;
    request_valid_next = request_valid_out;
    grant_index_next   = grant_index_out;
    issue_ack_next     = '0;
    load               = 1'b0;

    case (state)
      ARBITER_STATE_IDLE: begin
        load = found;
      end
      ARBITER_STATE_HOLD: begin
        if (issue_ack_in) begin
          if (found) begin
            load = 1'b1;
          end else begin
            state_next         = ARBITER_STATE_IDLE;
            request_next       = '0;
            request_valid_next = 1'b0;
            grant_index_next   = '0;
          end
        end
      end
      default: begin
        state_next = ARBITER_STATE_IDLE;
      end
    endcase

    if (load) begin
      state_next             = ARBITER_STATE_HOLD;
      request_next           = request_packed_in[int'(winner)*SINGLE_ENTRY_WIDTH_IN_BITS +: SINGLE_ENTRY_WIDTH_IN_BITS];
      request_valid_next     = 1'b1;
      grant_index_next       = winner;
      issue_ack_next[winner] = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state                <= ARBITER_STATE_IDLE;
      request_out          <= '0;
      request_valid_out    <= 1'b0;
      grant_index_out      <= '0;
      issue_ack_packed_out <= '0;
    end else begin
      state                <= state_next;
      request_out          <= request_next;
      request_valid_out    <= request_valid_next;
      grant_index_out      <= grant_index_next;
      issue_ack_packed_out <= issue_ack_next;
    end
  end

endmodule

// File: tb/tb_request_arbiter_rr.sv
// Bench for request_arbiter_rr: directed scenarios with literal expectations plus
// randomized clients and FIFO, checked every cycle against a behavioural model.
module tb_request_arbiter_rr;

  localparam int W = 512;
  localparam int N = 4;
  localparam int L = 2;
`ifdef ARBITER_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic           clk_in = 1'b0;
  logic           reset_in = 1'b0;
  logic [N*W-1:0] request_packed_in = '0;
  logic [N-1:0]   request_valid_packed_in = '0;
  logic [N-1:0]   issue_ack_packed_out;
  logic [W-1:0]   request_out;
  logic           request_valid_out;
  logic [L-1:0]   grant_index_out;
  logic           issue_ack_in = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  request_arbiter_rr #(
    .SINGLE_ENTRY_WIDTH_IN_BITS (W),
    .NUM_REQUESTER              (N),
    .NUM_REQUESTER_LOG2         (L)
  ) dut (
    .clk_in                  (clk_in),
    .reset_in                (reset_in),
    .request_packed_in       (request_packed_in),
    .request_valid_packed_in (request_valid_packed_in),
    .issue_ack_packed_out    (issue_ack_packed_out),
    .request_out             (request_out),
    .request_valid_out       (request_valid_out),
    .grant_index_out         (grant_index_out),
    .issue_ack_in            (issue_ack_in)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] r;
    for (int j = 0; j < W / 32; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction

  // Behavioural model: who wins is the first valid client at or after the pointer.
  function automatic int model_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  bit           m_hold = 1'b0;
  int           m_idx = 0;
  logic [W-1:0] m_data = '0;
  logic [N-1:0] m_ack = '0;
  int           m_ptr = 0;
  int           m_w;

  always @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      m_hold = 1'b0; m_idx = 0; m_data = '0; m_ack = '0; m_ptr = 0;
    end else begin
      m_ack = '0;
      if (!m_hold || issue_ack_in) begin
        m_w = model_pick(request_valid_packed_in, FIXED ? 0 : m_ptr);
        if (m_w >= 0) begin
          m_hold = 1'b1;
          m_idx = m_w;
          m_data = request_packed_in[m_w*W +: W];
          m_ack[m_w] = 1'b1;
          m_ptr = (m_w + 1) % N;
        end else begin
          m_hold = 1'b0; m_idx = 0; m_data = '0;
        end
      end
    end
  end

  always @(negedge clk_in) begin
    check("valid_out", W'(request_valid_out), W'(m_hold));
    check("request_out", request_out, m_data);
    check("ack_vec", W'(issue_ack_packed_out), W'(m_ack));
    if (m_hold) check("grant_idx", W'(grant_index_out), W'(m_idx));
  end

  // Client and FIFO behaviour, updated 1 time unit after each rising edge.
  bit           auto_drop = 1'b0;
  bit           rand_raise = 1'b0;
  bit           fifo_auto = 1'b1;
  bit           spurious_en = 1'b0;
  int           fifo_ready_pct = 100;
  bit           prev_vout = 1'b0;
  bit           prev_ack = 1'b0;
  int           cyc = 0;
  int           g_idx[$];
  int           g_cyc[$];
  logic [W-1:0] cdata[N];

  task automatic tick();
    logic nxt;
    @(posedge clk_in);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (issue_ack_packed_out[i]) begin
        g_idx.push_back(i);
        g_cyc.push_back(cyc);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (auto_drop && issue_ack_packed_out[i]) begin
        request_valid_packed_in[i] = 1'b0;
      end else if (rand_raise && !request_valid_packed_in[i] && $urandom_range(0, 3) == 0) begin
        request_valid_packed_in[i] = 1'b1;
        request_packed_in[i*W +: W] = rnd_word();
      end
    end
    if (fifo_auto) begin
      nxt = prev_vout && !prev_ack && (int'($urandom_range(1, 100)) <= fifo_ready_pct);
      if (!nxt && spurious_en && !prev_vout && !request_valid_out && $urandom_range(0, 7) == 0) nxt = 1'b1;
      issue_ack_in = nxt;
    end
    prev_vout = request_valid_out;
    prev_ack = issue_ack_in;
  endtask

  task automatic apply_reset();
    #2 reset_in = 1'b1;
    #1;
    check("rst_valid", W'(request_valid_out), '0);
    check("rst_data", request_out, '0);
    check("rst_ack", W'(issue_ack_packed_out), '0);
    check("rst_grant", W'(grant_index_out), '0);
    @(posedge clk_in);
    #1 reset_in = 1'b0;
    issue_ack_in = 1'b0;
    prev_vout = 1'b0;
    prev_ack = 1'b0;
  endtask

  int exp_g;

  initial begin
    #1 reset_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1 reset_in = 1'b0;
    check("init_valid", W'(request_valid_out), '0);
    check("init_data", request_out, '0);
    check("init_ack", W'(issue_ack_packed_out), '0);
    check("init_grant", W'(grant_index_out), '0);

    // Single client 2 with data 0xA5.
    request_packed_in[2*W +: W] = W'(8'hA5);
    request_valid_packed_in = 4'b0100;
    auto_drop = 1'b1;
    tick();
    check("single_valid", W'(request_valid_out), W'(1'b1));
    check("single_data", request_out, W'(8'hA5));
    check("single_grant", W'(grant_index_out), W'(2));
    check("single_ack", W'(issue_ack_packed_out), W'(4'b0100));
    tick();
    check("single_ack_low", W'(issue_ack_packed_out), '0);
    repeat (3) tick();
    check("single_idle", W'(request_valid_out), '0);

    // Wrap: pointer now 3, clients 0 and 1 held valid.
    auto_drop = 1'b0;
    request_packed_in[0 +: W] = rnd_word();
    request_packed_in[W +: W] = rnd_word();
    request_valid_packed_in = 4'b0011;
    g_idx.delete(); g_cyc.delete();
    tick();
    check("wrap_grant", W'(grant_index_out), '0);
    check("wrap_ack", W'(issue_ack_packed_out), W'(4'b0001));
    for (int k = 0; k < 8 && g_idx.size() < 2; k++) tick();
    check("wrap_count", W'(g_idx.size()), W'(2));
    if (g_idx.size() >= 2) check("wrap_second", W'(g_idx[1]), W'(FIXED ? 0 : 1));
    request_valid_packed_in = '0;
    repeat (4) tick();

    // Fairness: all clients held valid, FIFO always ready.
    apply_reset();
    for (int i = 0; i < N; i++) begin
      cdata[i] = rnd_word();
      request_packed_in[i*W +: W] = cdata[i];
    end
    request_valid_packed_in = '1;
    g_idx.delete(); g_cyc.delete();
    for (int k = 0; k < 30 && g_idx.size() < 5; k++) tick();
    check("fair_count", W'(g_idx.size()), W'(5));
    for (int k = 0; k < 5 && k < g_idx.size(); k++) begin
      check("fair_order", W'(g_idx[k]), W'(FIXED ? 0 : k % N));
      if (k > 0) check("fair_spacing", W'(g_cyc[k] - g_cyc[k-1]), W'(2));
    end

    // Backpressure: FIFO withholds its ack; client 0 is held.
    fifo_ready_pct = 0;
    repeat (2) tick();
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_valid", W'(request_valid_out), W'(1'b1));
      check("bp_data", request_out, cdata[0]);
      check("bp_grant", W'(grant_index_out), '0);
      check("bp_ack", W'(issue_ack_packed_out), '0);
    end
    fifo_ready_pct = 100;
    tick();
    tick();
    exp_g = FIXED ? 0 : 1;
    check("rel_grant", W'(grant_index_out), W'(exp_g));
    check("rel_ack", W'(issue_ack_packed_out), W'(1 << exp_g));
    check("rel_data", request_out, cdata[exp_g]);

    // Reset while holding, then only client 3 valid.
    apply_reset();
    request_valid_packed_in = 4'b1000;
    auto_drop = 1'b1;
    tick();
    check("post_rst_grant", W'(grant_index_out), W'(3));
    check("post_rst_ack", W'(issue_ack_packed_out), W'(4'b1000));
    check("post_rst_data", request_out, cdata[3]);
    repeat (4) tick();

    // Spurious FIFO ack while idle.
    request_valid_packed_in = '0;
    fifo_auto = 1'b0;
    issue_ack_in = 1'b1;
    repeat (2) tick();
    check("spur_valid", W'(request_valid_out), '0);
    check("spur_data", request_out, '0);
    check("spur_ack", W'(issue_ack_packed_out), '0);
    issue_ack_in = 1'b0;
    prev_ack = 1'b0;
    prev_vout = 1'b0;
    fifo_auto = 1'b1;

    // Random traffic with random FIFO backpressure and idle spurious acks.
    rand_raise = 1'b1;
    spurious_en = 1'b1;
    fifo_ready_pct = 70;
    repeat (3000) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/request_arbiter_rr.md
Name: request_arbiter_rr

Overview:
- N-to-1 round-robin arbiter directly upstream of the request FIFO in the memory subsystem.
- Collects requests from several clients and forwards one at a time to the FIFO.
- Uses the codebase valid/ack handshake on both sides.
- Acks the winning client when its request is latched, so the client is freed before the FIFO accepts it.

Parameters:
- SINGLE_ENTRY_WIDTH_IN_BITS, 512, width of one request.
- NUM_REQUESTER, 4, number of client ports (≥2).
- NUM_REQUESTER_LOG2, 2, width of the grant index, equal to ceil(log2(NUM_REQUESTER)).

Ports:
- clk_in  input  1  clock
- reset_in  input  1  reset; asynchronous, active-high
- request_packed_in  input  NUM_REQUESTER*SINGLE_ENTRY_WIDTH_IN_BITS  client requests; client i occupies slice [i*W +: W]
- request_valid_packed_in  input  NUM_REQUESTER  per-client valid, held until acked
- issue_ack_packed_out  output  NUM_REQUESTER  registered one-cycle ack to the winning client
- request_out  output  SINGLE_ENTRY_WIDTH_IN_BITS  latched winning request, to the FIFO's request_in
- request_valid_out  output  1  to the FIFO's request_valid_in
- grant_index_out  output  NUM_REQUESTER_LOG2  source index of request_out
- issue_ack_in  input  1  registered ack from the FIFO's issue_ack_out

Behaviour:
- Reset values: request_out=0, request_valid_out=0, issue_ack_packed_out=0, grant_index_out=0, priority pointer=0, state=IDLE.
- Reset is asynchronous. Asserting it mid-operation discards the held request. The client was already acked, so that request is lost by design; upper layers retry.
- States:
  - IDLE: nothing held.
  - HOLD: request_out is valid and waiting for issue_ack_in.
- Pick rule: first set bit of request_valid_packed_in, searching from priority pointer p upward with wrap NUM_REQUESTER-1 -> 0.
- IDLE with any valid:
  - register the winner w into request_out, grant_index_out=w, request_valid_out=1;
  - issue_ack_packed_out[w]=1 for exactly the next cycle;
  - p <= (w==NUM_REQUESTER-1) ? 0 : w+1;
  - go to HOLD.
  - Latency: client valid to request_valid_out is 1 cycle.
- IDLE with no valid: outputs hold 0.
- HOLD with issue_ack_in=0:
  - request_out, grant_index_out and request_valid_out are held stable;
  - the arbiter ignores request_valid_packed_in.
- HOLD with issue_ack_in=1 (back-to-back):
  - if any valid is present, load the next winner using the already-advanced p, ack it, and stay in HOLD; request_valid_out stays 1 with new data.
  - otherwise, request_valid_out<=0, request_out<=0, go to IDLE.
  - Sustained throughput: one request per 2 cycles. This matches the FIFO, which ignores valid during its own ack cycle.
- A client sees its ack while still driving valid. Because the arbiter is in HOLD, it never double-captures.
- At most one bit of issue_ack_packed_out is high in any cycle.
- issue_ack_in seen in IDLE is ignored.
- FIFO full: the FIFO withholds issue_ack_in, and HOLD persists indefinitely.

Optional Feature:
- Macro ARBITER_FIXED_PRIORITY_EN.
- Defined: p is forced to 0 permanently, so the lowest valid index always wins; the pointer register is not built.
- Undefined: round-robin as specified above.

Decomposition:
- The shared define header gets the state encodings ARBITER_STATE_IDLE=1'b0 and ARBITER_STATE_HOLD=1'b1, reusing the existing BYTE_LEN_IN_BITS define.
- One combinational sub-module, round_robin_pick. It takes the valid vector and pointer and returns a found flag and winner index. It is reusable by other arbiters.

Test Plan:
- Single client: client 2 valid with data 0xA5 in cycle 0.
  - Cycle 1: request_valid_out=1, request_out=0xA5, grant_index_out=2, issue_ack_packed_out=4'b0100.
  - Cycle 2: ack bit low.
- Fairness: all 4 clients continuously valid, FIFO acks each.
  - Grant order is 0,1,2,3,0, at one grant per 2 cycles.
  - With ARBITER_FIXED_PRIORITY_EN defined, the order is 0,0,0,…
- Backpressure: hold issue_ack_in=0 for 10 cycles.
  - request_out and grant_index_out are stable; no further client acks.
  - Release: next grant appears the cycle after issue_ack_in.
- Wrap: p=3, clients 0 and 1 valid -> client 0 wins; p becomes 1.
- Reset mid-HOLD: assert reset_in asynchronously.
  - All outputs are 0 immediately.
  - After release, client 3 valid wins first, since p=0 finds index 3 as the only valid.
- Spurious ack: issue_ack_in=1 in IDLE with no valid -> no state change, all outputs remain 0.
